// File: rtl/spi_master_mc_pkg.sv
// Shared encodings for the multi-chip-select SPI master: FSM states and
// bit positions of the {CPOL,CPHA} mode field.
package spi_master_mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LEAD  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } spi_state_e;

    localparam int unsigned MODE_CPOL = 1;
    localparam int unsigned MODE_CPHA = 0;

    // Phases in which the half-period timer runs.
    function automatic logic timed_state(input spi_state_e s);
        return (s == ST_SETUP) || (s == ST_LEAD) || (s == ST_TRAIL) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/spi_master_mc_timer.sv
// Half-period timer: counts 0..H and pulses tick_o on the last cycle of a phase,
// then wraps so back-to-back phases are each exactly H+1 cycles long.
module spi_master_mc_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] half_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tick_o = !clear_i && (cnt_q == half_i);

    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_mc.sv
// Full-duplex SPI master: CPOL/CPHA modes, MSB/LSB order, variable length,
// programmable SCK half-period and decoded active-low chip selects.
module spi_master_mc
    import spi_master_mc_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 32,
    parameter  int unsigned DELAY_WIDTH = 16,
    parameter  int unsigned NUM_CS      = 4,
    localparam int unsigned LEN_W       = $clog2(DATA_WIDTH),
    localparam int unsigned CS_W        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [1:0]             i_mode,
    input  logic                   i_lsb_first,
    input  logic [CS_W-1:0]        i_cs_sel,
    input  logic [LEN_W-1:0]       i_len,
    input  logic [DELAY_WIDTH-1:0] i_half_period,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic                   i_miso,
    output logic                   o_sck,
    output logic                   o_mosi,
    output logic [NUM_CS-1:0]      o_cs_n,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [DATA_WIDTH-1:0]  o_rx_data
);

    // Bit idx of the transfer order maps to data[idx] (LSB-first) or data[len-idx].
    function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] data,
                                      input logic [LEN_W-1:0]      len,
                                      input logic [LEN_W-1:0]      idx,
                                      input logic                  lsb);
        logic [LEN_W-1:0] pos;
        pos = lsb ? idx : (len - idx);
        return data[pos];
    endfunction

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] cs;
        cs = '1;
        for (int i = 0; i < int'(NUM_CS); i++) begin
            if (sel == CS_W'(i)) cs[i] = 1'b0;
        end
        return cs;
    endfunction

    spi_state_e              state_q;
    logic                    sck_q;
    logic                    mosi_q;
    logic [NUM_CS-1:0]       cs_n_q;
    logic                    busy_q;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   rx_data_q;
    logic [DATA_WIDTH-1:0]   tx_q;
    logic [DATA_WIDTH-1:0]   rx_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        bit_cnt_q;
    logic [LEN_W-1:0]        bit_cnt_d;
    logic [LEN_W-1:0]        rx_pos_d;
    logic [DELAY_WIDTH-1:0]  half_q;
    logic                    cpol_q;
    logic                    cpha_q;
    logic                    lsb_q;
    logic                    phase_end;
    logic                    last_bit;

    spi_master_mc_timer #(
        .WIDTH (DELAY_WIDTH)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clear_i (!timed_state(state_q)),
        .half_i  (half_q),
        .tick_o  (phase_end)
    );

    always_comb begin
        bit_cnt_d = bit_cnt_q + LEN_W'(1);
        rx_pos_d  = lsb_q ? bit_cnt_q : (len_q - bit_cnt_q);
        last_bit  = (bit_cnt_q == len_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            half_q    <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sck_q  <= i_mode[MODE_CPOL];
                    mosi_q <= 1'b0;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    cs_n_q <= '1;
                    if (i_start) begin
                        tx_q      <= i_data;
                        len_q     <= i_len;
                        half_q    <= i_half_period;
                        cpol_q    <= i_mode[MODE_CPOL];
                        cpha_q    <= i_mode[MODE_CPHA];
                        lsb_q     <= i_lsb_first;
                        bit_cnt_q <= '0;
                        rx_q      <= '0;
                        busy_q    <= 1'b1;
                        cs_n_q    <= cs_decode(i_cs_sel);
                        // CPHA=0 slaves sample on the first SCK edge, so bit 0 must already be out.
                        if (!i_mode[MODE_CPHA]) begin
                            mosi_q <= pick_bit(i_data, i_len, '0, i_lsb_first);
                        end
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (phase_end) begin
                        sck_q <= ~cpol_q;
                        if (cpha_q) begin
                            mosi_q <= pick_bit(tx_q, len_q, '0, lsb_q);
                        end
                        state_q <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (phase_end) begin
                        sck_q <= cpol_q;
                        if (!cpha_q) begin
                            rx_q[rx_pos_d] <= i_miso;
                            if (!last_bit) begin
                                mosi_q <= pick_bit(tx_q, len_q, bit_cnt_d, lsb_q);
                            end
                        end
                        state_q <= ST_TRAIL;
                    end
                end
                ST_TRAIL: begin
                    if (phase_end) begin
                        if (cpha_q) begin
                            rx_q[rx_pos_d] <= i_miso;
                        end
                        if (last_bit) begin
                            state_q <= ST_HOLD;
                        end else begin
                            bit_cnt_q <= bit_cnt_d;
                            sck_q     <= ~cpol_q;
                            if (cpha_q) begin
                                mosi_q <= pick_bit(tx_q, len_q, bit_cnt_d, lsb_q);
                            end
                            state_q <= ST_LEAD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (phase_end) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cs_n_q    <= '1;
                    done_q    <= 1'b1;
                    rx_data_q <= rx_q;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_sck     = sck_q;
    assign o_mosi    = mosi_q;
    assign o_cs_n    = cs_n_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_rx_data = rx_data_q;

    a_cs_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(~o_cs_n));
    a_done_busy:  assert property (@(posedge i_clk) disable iff (!i_rst_n) o_done |-> o_busy);

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: a behavioural SPI slave driven from the transfer task,
// randomized transfers, and a scoreboard of expected received words.
module tb_spi_master_mc;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [1:0]  i_mode;
    logic        i_lsb_first;
    logic [1:0]  i_cs_sel;
    logic [4:0]  i_len;
    logic [15:0] i_half_period;
    logic [31:0] i_data;
    logic        i_miso;
    logic        o_sck;
    logic        o_mosi;
    logic [3:0]  o_cs_n;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_rx_data;

    logic [31:0] exp_q[$];
    int          n_cmp;
    int          n_err;

    spi_master_mc dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_mode        (i_mode),
        .i_lsb_first   (i_lsb_first),
        .i_cs_sel      (i_cs_sel),
        .i_len         (i_len),
        .i_half_period (i_half_period),
        .i_data        (i_data),
        .i_miso        (i_miso),
        .o_sck         (o_sck),
        .o_mosi        (o_mosi),
        .o_cs_n        (o_cs_n),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_rx_data     (o_rx_data)
    );

    // Clock and watchdog
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Bit k of the serial order as seen on the wire for word w.
    function automatic logic wire_bit(input logic [31:0] w, input logic lsb, input int len, input int k);
        return lsb ? w[k] : w[len - k];
    endfunction

    // One full transfer with a model slave; poke_at = cycle index at which i_start
    // is pulsed again (-1 none, -2 the cycle before o_done).
    task automatic run_transfer(input logic [1:0] mode, input logic lsb, input logic [1:0] sel,
                                input int len, input int half, input logic [31:0] data,
                                input logic [31:0] sw, input int poke_at);
        logic        cpol;
        logic        cpha;
        logic        prev_sck;
        logic        seen;
        logic        cs_bad;
        logic        busy_bad;
        logic [31:0] mask;
        logic [31:0] got_tx;
        logic [3:0]  exp_cs;
        logic [31:0] exp_rx;
        logic        tx_bits[$];
        int          exp_lat;
        int          j;
        int          edges;
        int          sidx;
        int          poke;

        cpol     = mode[1];
        cpha     = mode[0];
        mask     = (len == 31) ? 32'hFFFF_FFFF : ((32'd1 << (len + 1)) - 32'd1);
        exp_lat  = (2 * len + 4) * (half + 1) + 1;
        exp_cs   = 4'hF ^ (4'h1 << sel);
        poke     = (poke_at == -2) ? exp_lat - 1 : poke_at;
        exp_q.push_back(sw & mask);

        @(negedge i_clk);
        i_mode        = mode;
        i_lsb_first   = lsb;
        i_cs_sel      = sel;
        i_len         = 5'(len);
        i_half_period = 16'(half);
        i_data        = data;
        i_start       = 1'b0;
        @(negedge i_clk);
        check("sck_idle", o_sck, cpol);
        i_start = 1'b1;
        @(negedge i_clk);

        j = 0; edges = 0; sidx = 0; seen = 0; cs_bad = 0; busy_bad = 0;
        prev_sck = cpol;
        tx_bits.delete();
        while (!seen && j <= exp_lat + 40) begin
            if (o_done === 1'b1) begin
                seen = 1;
            end else begin
                i_start = (j == poke);
                if (j == 0) begin
                    i_data        = $urandom;
                    i_len         = 5'($urandom_range(0, 31));
                    i_half_period = 16'($urandom_range(0, 7));
                    i_cs_sel      = 2'($urandom_range(0, 3));
                    i_lsb_first   = 1'($urandom_range(0, 1));
                    i_mode        = 2'($urandom_range(0, 3));
                    if (!cpha) i_miso = wire_bit(sw, lsb, len, 0);
                end
                if (o_busy !== 1'b1) busy_bad = 1;
                if (o_cs_n !== exp_cs) cs_bad = 1;
                if (o_sck !== prev_sck) begin
                    edges++;
                    if (o_sck !== cpol) begin
                        if (!cpha) tx_bits.push_back(o_mosi);
                        else begin
                            if (sidx <= len) i_miso = wire_bit(sw, lsb, len, sidx);
                            sidx++;
                        end
                    end else begin
                        if (cpha) tx_bits.push_back(o_mosi);
                        else begin
                            sidx++;
                            if (sidx <= len) i_miso = wire_bit(sw, lsb, len, sidx);
                        end
                    end
                    prev_sck = o_sck;
                end
                @(negedge i_clk);
                j++;
            end
        end
        i_start = 1'b0;

        exp_rx = exp_q.pop_front();
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", j, exp_lat);
            check("rx_data", o_rx_data, exp_rx);
            check("cs_at_done", o_cs_n, 4'hF);
            check("busy_at_done", o_busy, 1'b1);
        end
        got_tx = '0;
        for (int k = 0; k < tx_bits.size() && k <= len; k++) begin
            if (lsb) got_tx[k] = tx_bits[k];
            else     got_tx[len - k] = tx_bits[k];
        end
        check("mosi_bits", tx_bits.size(), len + 1);
        check("mosi_word", got_tx, data & mask);
        check("sck_edges", edges, 2 * (len + 1));
        check("cs_during", cs_bad, 1'b0);
        check("busy_during", busy_bad, 1'b0);

        @(negedge i_clk);
        check("done_pulse", o_done, 1'b0);
        check("busy_after", o_busy, 1'b0);
    endtask

    initial begin
        int k;
        int dcount;
        int len;
        int half;
        n_cmp = 0;
        n_err = 0;

        i_rst_n       = 1'b0;
        i_start       = 1'b0;
        i_mode        = 2'b00;
        i_lsb_first   = 1'b0;
        i_cs_sel      = 2'd0;
        i_len         = 5'd0;
        i_half_period = 16'd0;
        i_data        = 32'd0;
        i_miso        = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_sck", o_sck, 1'b0);
        check("rst_mosi", o_mosi, 1'b0);
        check("rst_cs", o_cs_n, 4'hF);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_rx", o_rx_data, 32'd0);
        i_rst_n = 1'b1;

        run_transfer(2'd0, 1'b0, 2'd0, 7, 1, 32'h0000_00A5, 32'h0000_00A5, -1);
        run_transfer(2'd3, 1'b1, 2'd1, 15, 0, 32'h0000_1234, 32'h0000_00FF, -1);
        run_transfer(2'd1, 1'b0, 2'd3, 0, 1, $urandom, $urandom, -1);
        run_transfer(2'd2, 1'b1, 2'd0, 0, 2, $urandom, $urandom, -1);
        run_transfer(2'd0, 1'b0, 2'd2, 31, 3, $urandom, $urandom, 50);
        run_transfer(2'd1, 1'b1, 2'd1, 3, 1, $urandom, $urandom, -2);

        for (int t = 0; t < 12; t++) begin
            len  = $urandom_range(0, 31);
            half = $urandom_range(0, 3);
            run_transfer(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         len, half, $urandom, $urandom,
                         ($urandom_range(0, 2) == 0) ? -1 : (($urandom_range(0, 1) == 0) ? -2 : int'($urandom_range(1, 20))));
        end

        // Reset while SCK is in its leading (active) phase
        @(negedge i_clk);
        i_mode        = 2'b00;
        i_lsb_first   = 1'b0;
        i_cs_sel      = 2'd1;
        i_len         = 5'd7;
        i_half_period = 16'd2;
        i_data        = $urandom;
        i_start       = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        k = 0;
        while (o_sck !== 1'b1 && k < 100) begin
            @(negedge i_clk);
            k++;
        end
        check("reach_lead", (k < 100), 1'b1);
        check("cs_in_lead", o_cs_n, 4'b1101);
        i_rst_n = 1'b0;
        #1;
        check("abort_sck", o_sck, 1'b0);
        check("abort_cs", o_cs_n, 4'hF);
        check("abort_busy", o_busy, 1'b0);
        check("abort_done", o_done, 1'b0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_done === 1'b1) dcount++;
        end
        check("no_done_after_abort", dcount, 0);
        check("idle_after_abort", o_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
